// File: rtl/id_operand_stage_if.sv
// ---------------------------------------------------------------------------
// id_operand_stage_if
// Bundles the decode-side request, the forwarding bus and the ID/EX output
// bus of id_operand_stage.
//   master : decode/regfile/forwarding side plus the EX consumer
//            (drives in_*, fwd_*, out_ready; observes in_ready and out_*)
//   slave  : the operand stage itself
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid, once raised, holds its payload stable until it is accepted.
// ---------------------------------------------------------------------------
interface id_operand_stage_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_FWD = 2
);
    // decode side
    logic                      in_valid;
    logic                      in_ready;
    logic [ADDR_W-1:0]         addr;
    logic [5:0]                op;
    logic [5:0]                funct;
    logic [15:0]               imm;
    logic [4:0]                rs_idx;
    logic [4:0]                rt_idx;
    logic [DATA_W-1:0]         reg_data_1;
    logic [DATA_W-1:0]         reg_data_2;
    // forwarding sources, index 0 is the nearest stage
    logic [NUM_FWD-1:0]        fwd_valid;
    logic [NUM_FWD-1:0]        fwd_pend;
    logic [NUM_FWD*5-1:0]      fwd_idx;
    logic [NUM_FWD*DATA_W-1:0] fwd_data;
    // ID/EX boundary
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         operand_1;
    logic [DATA_W-1:0]         operand_2;
    logic [DATA_W-1:0]         store_data;

    modport master (
        output in_valid, addr, op, funct, imm, rs_idx, rt_idx,
               reg_data_1, reg_data_2,
               fwd_valid, fwd_pend, fwd_idx, fwd_data, out_ready,
        input  in_ready, out_valid, operand_1, operand_2, store_data
    );

    modport slave (
        input  in_valid, addr, op, funct, imm, rs_idx, rt_idx,
               reg_data_1, reg_data_2,
               fwd_valid, fwd_pend, fwd_idx, fwd_data, out_ready,
        output in_ready, out_valid, operand_1, operand_2, store_data
    );
endinterface

// File: rtl/id_operand_stage.sv
// ---------------------------------------------------------------------------
// id_operand_stage
// ID-stage operand generator: builds operand_1 / operand_2 / store_data from
// the decoded fields, resolves NUM_FWD-way forwarding, detects load-use
// hazards and registers the result into the ID/EX boundary.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   flush     synchronous flush: drops the output, consumes and discards in_*
//   bus       id_operand_stage_if.slave (decode, forwarding, ID/EX signals)
//   stall_cnt saturating count of cycles lost to load-use hazards
// ---------------------------------------------------------------------------
module id_operand_stage #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int NUM_FWD      = 2,
    parameter int LINK_OFFSET  = 8,
    parameter int IMM_LOGIC_HI = 1,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    id_operand_stage_if.slave  bus,
    output logic [CNT_W-1:0]   stall_cnt
);
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FN_JALR    = 6'h09;

    logic              is_special, is_jalr, is_link, is_load, is_store, is_logic;
    logic              use_rs, use_rt;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              rs_pend, rt_pend;
    logic              hazard, load;
    logic [ADDR_W-1:0] link_addr;
    logic [DATA_W-1:0] imm_sext, imm_zext, imm_hi;
    logic [DATA_W-1:0] op1_next, op2_next, store_next;

    // ---------------- decode ----------------
    always_comb begin
        is_special = (bus.op == OP_SPECIAL);
        is_jalr    = is_special && (bus.funct == FN_JALR);
        is_link    = (bus.op == OP_JAL) || is_jalr;
        is_load    = bus.op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        is_store   = bus.op inside {OP_SB, OP_SH, OP_SW};
        is_logic   = bus.op inside {OP_ANDI, OP_ORI, OP_XORI};
        use_rs     = (bus.op inside {OP_ADDIU, OP_LUI}) || is_logic || is_load
                     || is_store || (is_special && !is_jalr);
        use_rt     = is_special || is_store;
    end

    // ---------------- forwarding ----------------
    // Walk from the farthest source to the nearest so that the lowest matching
    // index wins; its pend bit alone decides the hazard.
    always_comb begin
        rs_val  = bus.reg_data_1;
        rs_pend = 1'b0;
        rt_val  = bus.reg_data_2;
        rt_pend = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (bus.fwd_valid[i] && (bus.fwd_idx[5*i +: 5] == bus.rs_idx)
                && (bus.rs_idx != 5'd0)) begin
                rs_val  = bus.fwd_data[DATA_W*i +: DATA_W];
                rs_pend = bus.fwd_pend[i];
            end
            if (bus.fwd_valid[i] && (bus.fwd_idx[5*i +: 5] == bus.rt_idx)
                && (bus.rt_idx != 5'd0)) begin
                rt_val  = bus.fwd_data[DATA_W*i +: DATA_W];
                rt_pend = bus.fwd_pend[i];
            end
        end
    end

    // An unused source can never stall the stage.
    assign hazard = (use_rs && rs_pend) || (use_rt && rt_pend);

    // ---------------- operand build ----------------
    always_comb begin
        link_addr = bus.addr + ADDR_W'(LINK_OFFSET);
        imm_sext  = {{(DATA_W-16){bus.imm[15]}}, bus.imm};
        imm_zext  = DATA_W'(bus.imm);
        imm_hi    = DATA_W'({bus.imm, 16'h0000});

        op1_next = '0;
        if (is_link)
            op1_next = DATA_W'(link_addr);
        else if (use_rs)
            op1_next = rs_val;

        op2_next = '0;
        if (bus.op == OP_LUI)
            op2_next = imm_hi;
        else if (is_logic)
            op2_next = (IMM_LOGIC_HI != 0) ? imm_hi : imm_zext;
        else if ((bus.op == OP_ADDIU) || is_load || is_store)
            op2_next = imm_sext;
        else if (is_special)
            op2_next = rt_val;

        store_next = is_store ? rt_val : '0;
    end

    // ---------------- handshake ----------------
    // Flush forces acceptance so the pending input is swallowed.
    assign bus.in_ready = flush || (!hazard && (!bus.out_valid || bus.out_ready));
    assign load         = bus.in_valid && bus.in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.operand_1  <= '0;
            bus.operand_2  <= '0;
            bus.store_data <= '0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
        end else if (load) begin
            bus.out_valid  <= 1'b1;
            bus.operand_1  <= op1_next;
            bus.operand_2  <= op2_next;
            bus.store_data <= store_next;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (!flush && bus.in_valid && hazard && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_id_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_id_operand_stage
// Directed bench for id_operand_stage (CNT_W=4 so saturation is reachable).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_id_operand_stage;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] stall_cnt;
    int         n_vec  = 0;
    int         n_miss = 0;

    id_operand_stage_if #(.ADDR_W(32), .DATA_W(32), .NUM_FWD(2)) bus ();

    id_operand_stage #(
        .ADDR_W(32), .DATA_W(32), .NUM_FWD(2), .LINK_OFFSET(8),
        .IMM_LOGIC_HI(1), .CNT_W(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_fwd(input logic [1:0] v, input logic [1:0] p,
                           input logic [4:0] i0, input logic [4:0] i1,
                           input logic [31:0] d0, input logic [31:0] d1);
        bus.fwd_valid = v;
        bus.fwd_pend  = p;
        bus.fwd_idx   = {i1, i0};
        bus.fwd_data  = {d1, d0};
    endtask

    task automatic set_instr(input logic [5:0] o, input logic [5:0] f,
                             input logic [15:0] im, input logic [4:0] s,
                             input logic [4:0] t, input logic [31:0] a,
                             input logic [31:0] d1, input logic [31:0] d2);
        bus.in_valid   = 1'b1;
        bus.op         = o;
        bus.funct      = f;
        bus.imm        = im;
        bus.rs_idx     = s;
        bus.rt_idx     = t;
        bus.addr       = a;
        bus.reg_data_1 = d1;
        bus.reg_data_2 = d2;
    endtask

    task automatic idle();
        set_instr(6'h3F, 6'h00, 16'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        bus.in_valid = 1'b0;
        set_fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    endtask

    initial begin
        idle();
        bus.out_ready = 1'b1;

        // reset state
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_op1", bus.operand_1, 32'h0);
        check("rst_op2", bus.operand_2, 32'h0);
        check("rst_store", bus.store_data, 32'h0);
        check("rst_stall", 32'(stall_cnt), 32'h0);
        #4 rst_n = 1'b1;
        tick();

        // ADDIU sign-extended immediate, latency 1
        set_instr(6'h09, 6'h00, 16'hFFFE, 5'd3, 5'd0, 32'h0, 32'h5, 32'h0);
        #1 check("addiu_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        check("addiu_valid", 32'(bus.out_valid), 32'h1);
        check("addiu_op1", bus.operand_1, 32'h5);
        check("addiu_op2", bus.operand_2, 32'hFFFFFFFE);
        check("addiu_store", bus.store_data, 32'h0);

        // JAL link address
        set_instr(6'h03, 6'h00, 16'h1234, 5'd0, 5'd0, 32'h00400010, 32'h9, 32'h9);
        tick();
        check("jal_op1", bus.operand_1, 32'h00400018);
        check("jal_op2", bus.operand_2, 32'h0);

        // SPECIAL JALR: same link, op2 from rt
        set_instr(6'h00, 6'h09, 16'h0, 5'd0, 5'd0, 32'h00400010, 32'h9, 32'h11);
        tick();
        check("jalr_op1", bus.operand_1, 32'h00400018);
        check("jalr_op2", bus.operand_2, 32'h11);

        // two matching sources: nearest wins, its pend=0 so no hazard
        set_instr(6'h00, 6'h21, 16'h0, 5'd4, 5'd4, 32'h0, 32'h1, 32'h2);
        set_fwd(2'b11, 2'b10, 5'd4, 5'd4, 32'hAAAA0001, 32'hBBBB0002);
        #1 check("prio_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        check("prio_op1", bus.operand_1, 32'hAAAA0001);
        check("prio_op2", bus.operand_2, 32'hAAAA0001);

        // register 0 is never forwarded
        set_instr(6'h00, 6'h21, 16'h0, 5'd0, 5'd0, 32'h0, 32'h1234, 32'h5678);
        set_fwd(2'b11, 2'b00, 5'd0, 5'd0, 32'hAAAA0001, 32'hBBBB0002);
        tick();
        check("r0_op1", bus.operand_1, 32'h1234);
        check("r0_op2", bus.operand_2, 32'h5678);

        // only the far source matches rs
        set_instr(6'h00, 6'h21, 16'h0, 5'd5, 5'd9, 32'h0, 32'h1, 32'h77);
        set_fwd(2'b11, 2'b00, 5'd6, 5'd5, 32'hAAAA0001, 32'hBBBB0002);
        tick();
        check("fwd1_op1", bus.operand_1, 32'hBBBB0002);
        check("fwd1_op2", bus.operand_2, 32'h77);

        // ORI with IMM_LOGIC_HI=1
        set_fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        set_instr(6'h0D, 6'h00, 16'h00F0, 5'd0, 5'd0, 32'h0, 32'h77, 32'h0);
        tick();
        check("ori_op1", bus.operand_1, 32'h77);
        check("ori_op2", bus.operand_2, 32'h00F00000);

        // load-use hazard for 2 cycles
        set_instr(6'h23, 6'h00, 16'h0004, 5'd7, 5'd0, 32'h0, 32'h1, 32'h0);
        set_fwd(2'b01, 2'b01, 5'd7, 5'd0, 32'hDEAD0000, 32'h0);
        #1 check("haz_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        check("haz_bubble", 32'(bus.out_valid), 32'h0);
        check("haz_cnt1", 32'(stall_cnt), 32'h1);
        tick();
        bus.fwd_pend = 2'b00;
        #1 check("haz_cnt2", 32'(stall_cnt), 32'h2);
        check("haz_release", 32'(bus.in_ready), 32'h1);
        tick();
        check("haz_valid", 32'(bus.out_valid), 32'h1);
        check("haz_op1", bus.operand_1, 32'hDEAD0000);
        check("haz_op2", bus.operand_2, 32'h4);

        // JAL ignores a pending match on its unused rs field
        set_instr(6'h03, 6'h00, 16'h0, 5'd7, 5'd7, 32'h00400100, 32'h0, 32'h0);
        set_fwd(2'b01, 2'b01, 5'd7, 5'd0, 32'h0, 32'h0);
        #1 check("jal_nostall", 32'(bus.in_ready), 32'h1);
        tick();
        check("jal2_op1", bus.operand_1, 32'h00400108);
        check("jal2_cnt", 32'(stall_cnt), 32'h2);

        // SW then held stall
        set_fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        set_instr(6'h2B, 6'h00, 16'hFFF0, 5'd2, 5'd3, 32'h0, 32'h100, 32'hCAFEF00D);
        tick();
        check("sw_op1", bus.operand_1, 32'h100);
        check("sw_op2", bus.operand_2, 32'hFFFFFFF0);
        check("sw_store", bus.store_data, 32'hCAFEF00D);
        bus.out_ready = 1'b0;
        set_instr(6'h09, 6'h00, 16'h0001, 5'd1, 5'd0, 32'h0, 32'h55, 32'h0);
        #1 check("hold_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        check("hold_valid", 32'(bus.out_valid), 32'h1);
        check("hold_op1", bus.operand_1, 32'h100);
        tick();
        check("hold_store", bus.store_data, 32'hCAFEF00D);
        check("hold_op2", bus.operand_2, 32'hFFFFFFF0);

        // flush with a hazardous instruction presented
        flush = 1'b1;
        set_instr(6'h23, 6'h00, 16'h0, 5'd7, 5'd0, 32'h0, 32'h0, 32'h0);
        set_fwd(2'b01, 2'b01, 5'd7, 5'd0, 32'h0, 32'h0);
        #1 check("flush_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        check("flush_valid", 32'(bus.out_valid), 32'h0);
        check("flush_cnt", 32'(stall_cnt), 32'h2);
        flush = 1'b0;
        idle();
        tick();
        check("flush_discard", 32'(bus.out_valid), 32'h0);

        // saturation: 19 hazard cycles from count 2
        bus.out_ready = 1'b1;
        set_instr(6'h23, 6'h00, 16'h0004, 5'd7, 5'd0, 32'h0, 32'h0, 32'h0);
        set_fwd(2'b01, 2'b01, 5'd7, 5'd0, 32'hDEAD0000, 32'h0);
        for (int k = 0; k < 19; k++) tick();
        check("sat_cnt", 32'(stall_cnt), 32'hF);
        check("sat_valid", 32'(bus.out_valid), 32'h0);
        bus.fwd_pend = 2'b00;
        tick();
        check("sat_issue_op1", bus.operand_1, 32'hDEAD0000);
        check("sat_issue_valid", 32'(bus.out_valid), 32'h1);

        // asynchronous reset mid-transfer
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'h0);
        check("arst_op1", bus.operand_1, 32'h0);
        check("arst_op2", bus.operand_2, 32'h0);
        check("arst_cnt", 32'(stall_cnt), 32'h0);
        idle();
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(bus.in_ready), 32'h1);
        check("post_rst_valid", 32'(bus.out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
